// File: rtl/issue_unit_arbiter_if.sv
// Issue unit arbiter bus: per-warp issue/exit request-grant pairs,
// OC back-pressure, and the statistics counters.
interface issue_unit_arbiter_if #(
  parameter int NUM_WARPS = 8,
  parameter int CNT_WIDTH = 32
);
  logic [NUM_WARPS-1:0] Req_IB_IU;
  logic [NUM_WARPS-1:0] Grt_IU_IB;
  logic [NUM_WARPS-1:0] Exit_Req_IB_IU;
  logic [NUM_WARPS-1:0] Exit_Grt_IU_IB;
  logic                 Full_OC_IU;
  logic [CNT_WIDTH-1:0] Issue_Count_IU;
  logic [CNT_WIDTH-1:0] Stall_Count_IU;

  // Instruction-buffer / OC side: raises requests, observes grants.
  modport master (
    output Req_IB_IU, Exit_Req_IB_IU, Full_OC_IU,
    input  Grt_IU_IB, Exit_Grt_IU_IB, Issue_Count_IU, Stall_Count_IU
  );

  // Arbiter side.
  modport slave (
    input  Req_IB_IU, Exit_Req_IB_IU, Full_OC_IU,
    output Grt_IU_IB, Exit_Grt_IU_IB, Issue_Count_IU, Stall_Count_IU
  );
endinterface

// File: rtl/issue_unit_arbiter.sv
// Issue unit arbiter: round-robin issue grant to the OC (gated by OC full)
// and independent round-robin exit grant, plus issue/stall statistics.
module issue_unit_arbiter #(
  parameter int NUM_WARPS    = 8,
  parameter int LOGNUM_WARPS = $clog2(NUM_WARPS),
  parameter int CNT_WIDTH    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  issue_unit_arbiter_if.slave    bus
);
  typedef int unsigned uint_t;
  localparam uint_t NW = uint_t'(NUM_WARPS);

  logic [LOGNUM_WARPS-1:0] rr_ptr_q, rr_ptr_d;
  logic [LOGNUM_WARPS-1:0] ex_ptr_q, ex_ptr_d;
  logic [CNT_WIDTH-1:0]    issue_cnt_q, issue_cnt_d;
  logic [CNT_WIDTH-1:0]    stall_cnt_q, stall_cnt_d;
  logic [LOGNUM_WARPS:0]   iss_sel;   // {valid, warp index}
  logic [LOGNUM_WARPS:0]   ex_sel;
  logic [NUM_WARPS-1:0]    exit_cand;
  logic [NUM_WARPS-1:0]    grt;
  logic [NUM_WARPS-1:0]    ex_grt;

  // First requester at or after ptr, wrapping modulo NUM_WARPS (not 2^n).
  function automatic logic [LOGNUM_WARPS:0] rr_pick(
    input logic [NUM_WARPS-1:0]    req,
    input logic [LOGNUM_WARPS-1:0] ptr
  );
    logic [LOGNUM_WARPS:0] res;
    uint_t idx;
    res = '0;
    for (int unsigned i = 0; i < NW; i++) begin
      idx = uint_t'(ptr) + i;
      if (idx >= NW) idx = idx - NW;
      if (!res[LOGNUM_WARPS] && req[LOGNUM_WARPS'(idx)])
        res = {1'b1, LOGNUM_WARPS'(idx)};
    end
    return res;
  endfunction

  function automatic logic [LOGNUM_WARPS-1:0] next_ptr(input logic [LOGNUM_WARPS-1:0] w);
    return (w == LOGNUM_WARPS'(NW - 1)) ? '0 : w + 1'b1;
  endfunction

  // Combinational grant selection; reset forces both grants low at once.
  always_comb begin
    exit_cand = bus.Exit_Req_IB_IU & ~bus.Req_IB_IU;
    iss_sel   = (rst || bus.Full_OC_IU) ? '0 : rr_pick(bus.Req_IB_IU, rr_ptr_q);
    ex_sel    = rst ? '0 : rr_pick(exit_cand, ex_ptr_q);
    grt       = '0;
    ex_grt    = '0;
    if (iss_sel[LOGNUM_WARPS]) grt[iss_sel[LOGNUM_WARPS-1:0]]   = 1'b1;
    if (ex_sel[LOGNUM_WARPS])  ex_grt[ex_sel[LOGNUM_WARPS-1:0]] = 1'b1;
  end

  // Next-state for pointers and statistics counters.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    ex_ptr_d    = ex_ptr_q;
    issue_cnt_d = issue_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (iss_sel[LOGNUM_WARPS]) begin
      rr_ptr_d    = next_ptr(iss_sel[LOGNUM_WARPS-1:0]);
      issue_cnt_d = issue_cnt_q + CNT_WIDTH'(1);
    end
    if (ex_sel[LOGNUM_WARPS]) ex_ptr_d = next_ptr(ex_sel[LOGNUM_WARPS-1:0]);
    if (bus.Full_OC_IU && (|bus.Req_IB_IU) && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      ex_ptr_q    <= '0;
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      ex_ptr_q    <= ex_ptr_d;
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.Grt_IU_IB      = grt;
  assign bus.Exit_Grt_IU_IB = ex_grt;
  assign bus.Issue_Count_IU = issue_cnt_q;
  assign bus.Stall_Count_IU = stall_cnt_q;
endmodule

// File: tb/tb_issue_unit_arbiter.sv
// Bench for issue_unit_arbiter: an 8-warp and a 6-warp instance driven in
// lock-step, compared against a modulo-arithmetic round-robin model.
module tb_issue_unit_arbiter;
  logic clk;
  logic rst;
  int total = 0;
  int bad   = 0;

  issue_unit_arbiter_if #(.NUM_WARPS(8), .CNT_WIDTH(32)) if8 ();
  issue_unit_arbiter_if #(.NUM_WARPS(6), .CNT_WIDTH(32)) if6 ();

  issue_unit_arbiter #(.NUM_WARPS(8), .CNT_WIDTH(32)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
  issue_unit_arbiter #(.NUM_WARPS(6), .CNT_WIDTH(32)) dut6 (.clk(clk), .rst(rst), .bus(if6.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference state, index 0 = 8 warps, index 1 = 6 warps.
  int          nw[2] = '{8, 6};
  int          rr[2];
  int          ex[2];
  logic [31:0] icnt[2];
  logic [31:0] scnt[2];
  logic [7:0]  rq[2];
  logic [7:0]  eq[2];
  logic        fl[2];
  logic [7:0]  exp_g[2];
  logic [7:0]  exp_e[2];
  int          exp_gw[2];
  int          exp_ew[2];

  function automatic logic [7:0] nmask(input int n);
    return (n == 8) ? 8'hFF : 8'h3F;
  endfunction

  // Round robin from the spec: first requester among ptr, ptr+1, ... mod n.
  function automatic logic [7:0] pick(input logic [7:0] req, input int ptr, input int n, output int w);
    logic [7:0] r;
    r = req;
    w = -1;
    for (int k = 0; k < n; k++) begin
      if (w < 0 && r[(ptr + k) % n]) w = (ptr + k) % n;
    end
    return (w < 0) ? 8'h00 : (8'h01 << w);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      rr[i] = 0; ex[i] = 0; icnt[i] = '0; scnt[i] = '0;
    end
  endtask

  task automatic drive(input logic [7:0] r8, input logic [7:0] e8, input logic f8,
                       input logic [7:0] r6, input logic [7:0] e6, input logic f6);
    rq[0] = r8; eq[0] = e8; fl[0] = f8;
    rq[1] = r6 & 8'h3F; eq[1] = e6 & 8'h3F; fl[1] = f6;
    if8.Req_IB_IU = r8; if8.Exit_Req_IB_IU = e8; if8.Full_OC_IU = f8;
    if6.Req_IB_IU = r6[5:0]; if6.Exit_Req_IB_IU = e6[5:0]; if6.Full_OC_IU = f6;
  endtask

  task automatic check_grants();
    logic [7:0] og, oe, m;
    for (int i = 0; i < 2; i++) begin
      m = nmask(nw[i]);
      exp_g[i] = fl[i] ? 8'h00 : pick(rq[i] & m, rr[i], nw[i], exp_gw[i]);
      if (fl[i]) exp_gw[i] = -1;
      exp_e[i] = pick(eq[i] & ~rq[i] & m, ex[i], nw[i], exp_ew[i]);
      og = (i == 0) ? if8.Grt_IU_IB : {2'b00, if6.Grt_IU_IB};
      oe = (i == 0) ? if8.Exit_Grt_IU_IB : {2'b00, if6.Exit_Grt_IU_IB};
      check($sformatf("grt[n=%0d]", nw[i]), {24'd0, og}, {24'd0, exp_g[i]});
      check($sformatf("exit_grt[n=%0d]", nw[i]), {24'd0, oe}, {24'd0, exp_e[i]});
      check($sformatf("grt_onehot0[n=%0d]", nw[i]), {31'd0, $onehot0(og)}, 32'd1);
      check($sformatf("grt_overlap[n=%0d]", nw[i]), {24'd0, og & oe}, 32'd0);
      check($sformatf("grt_unrequested[n=%0d]", nw[i]), {24'd0, og & ~rq[i]}, 32'd0);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (exp_gw[i] >= 0) begin
        rr[i] = (exp_gw[i] + 1) % nw[i];
        icnt[i] = icnt[i] + 32'd1;
      end
      if (exp_ew[i] >= 0) ex[i] = (exp_ew[i] + 1) % nw[i];
      if (fl[i] && (rq[i] != 8'h00) && (scnt[i] != 32'hFFFF_FFFF)) scnt[i] = scnt[i] + 32'd1;
    end
  endtask

  task automatic check_counts();
    check("issue_cnt[n=8]", if8.Issue_Count_IU, icnt[0]);
    check("stall_cnt[n=8]", if8.Stall_Count_IU, scnt[0]);
    check("issue_cnt[n=6]", if6.Issue_Count_IU, icnt[1]);
    check("stall_cnt[n=6]", if6.Stall_Count_IU, scnt[1]);
  endtask

  // One clock cycle: drive at edge+1, check grants mid-cycle, check state after edge.
  task automatic cyc(input logic [7:0] r8, input logic [7:0] e8, input logic f8,
                     input logic [7:0] r6, input logic [7:0] e6, input logic f6);
    drive(r8, e8, f8, r6, e6, f6);
    #3;
    check_grants();
    @(posedge clk);
    model_edge();
    #1;
    check_counts();
  endtask

  initial begin
    logic [7:0] seq8[$];
    model_reset();
    rst = 1'b1;
    drive(8'hFF, 8'hFF, 1'b0, 8'hFF, 8'hFF, 1'b0);
    #2;
    check("reset_grt8", {24'd0, if8.Grt_IU_IB}, 32'd0);
    check("reset_exit8", {24'd0, if8.Exit_Grt_IU_IB}, 32'd0);
    check("reset_grt6", {26'd0, if6.Grt_IU_IB}, 32'd0);
    check_counts();
    @(posedge clk); #1;
    rst = 1'b0;

    // All warps requesting: 0..7 then 0 on the 8-warp unit, 0..5 then 0,1,2 on 6.
    for (int i = 0; i < 9; i++) begin
      cyc(8'hFF, 8'h00, 1'b0, 8'hFF, 8'h00, 1'b0);
      seq8.push_back(exp_g[0]);
    end
    check("seq_first", {24'd0, seq8[0]}, 32'h01);
    check("seq_last7", {24'd0, seq8[7]}, 32'h80);
    check("seq_wrap", {24'd0, seq8[8]}, 32'h01);
    check("issue_cnt9", if8.Issue_Count_IU, 32'd9);

    // Warps 0 and 7 only: alternating with wrap from 7 back to 0.
    for (int i = 0; i < 4; i++) cyc(8'h81, 8'h00, 1'b0, 8'h21, 8'h00, 1'b0);

    // OC full stall for 5 cycles, then release.
    for (int i = 0; i < 5; i++) cyc(8'h0F, 8'h00, 1'b1, 8'h0F, 8'h00, 1'b1);
    check("stall_cnt5", if8.Stall_Count_IU, 32'd5);
    cyc(8'h0F, 8'h00, 1'b0, 8'h0F, 8'h00, 1'b0);

    // Simultaneous issue and exit to different warps.
    cyc(8'h04, 8'h24, 1'b0, 8'h04, 8'h24, 1'b0);
    check("simul_grt", {24'd0, exp_g[0]}, 32'h04);
    check("simul_exit", {24'd0, exp_e[0]}, 32'h20);
    check("simul_rr", rr[0], 32'd3);
    check("simul_ex", ex[0], 32'd6);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      cyc(8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0),
          8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
    end

    // Asynchronous reset mid-cycle while grants are active.
    drive(8'hFF, 8'h00, 1'b0, 8'hFF, 8'h00, 1'b0);
    #2;
    check_grants();
    rst = 1'b1;
    #1;
    model_reset();
    check("async_grt8", {24'd0, if8.Grt_IU_IB}, 32'd0);
    check("async_grt6", {26'd0, if6.Grt_IU_IB}, 32'd0);
    check_counts();
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(8'hFF, 8'hFF, 1'b0, 8'hFF, 8'h00, 1'b0);
    check("post_reset_grt", {24'd0, exp_g[0]}, 32'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/issue_unit_arbiter.md
Name: issue_unit_arbiter

Overview:
- Issue Unit (IU) arbiter between the per-warp instruction buffers and the Operand Collector (OC) / RAU exit path.
- Each cycle it grants at most one ready warp to issue to the OC, and at most one exiting warp to the RAU/TM path.
- Both paths use round-robin arbitration with registered priority pointers.
- OC back-pressure is honoured, and the block keeps issue and stall statistics counters.

Parameters:
- NUM_WARPS, 8, number of warps / requesters; any value >= 2, not required to be a power of 2.
- LOGNUM_WARPS, $clog2(NUM_WARPS), width of the pointer and warp-ID fields.
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- Req_IB_IU  input  NUM_WARPS  per-warp issue request (instruction ready and scoreboard-clear).
- Grt_IU_IB  output  NUM_WARPS  issue grant; one-hot or zero; combinational in the same cycle as the request.
- Exit_Req_IB_IU  input  NUM_WARPS  per-warp exit request.
- Exit_Grt_IU_IB  output  NUM_WARPS  exit grant; one-hot or zero; combinational.
- Full_OC_IU  input  1  OC cannot accept an instruction this cycle.
- Issue_Count_IU  output  CNT_WIDTH  registered count of issue grants.
- Stall_Count_IU  output  CNT_WIDTH  registered count of OC-full stall cycles.

Behaviour:
- Reset (rst=1, asynchronous):
  - RR_Ptr=0, Exit_Ptr=0, Issue_Count_IU=0, Stall_Count_IU=0.
  - Grt_IU_IB and Exit_Grt_IU_IB are forced to 0 while rst=1, regardless of requests.
  - A reset asserted mid-cycle drops any grant immediately.
- Issue arbitration (combinational, zero latency):
  - Search order is RR_Ptr, RR_Ptr+1, ..., wrapping modulo NUM_WARPS.
  - The first warp w with Req_IB_IU[w]=1 gets Grt_IU_IB[w]=1.
  - When Full_OC_IU=1, Grt_IU_IB=0 regardless of requests.
  - No requests -> Grt_IU_IB=0.
- Issue pointer update: on a clock edge where an issue grant to warp w occurred, RR_Ptr <= (w+1) mod NUM_WARPS. Otherwise RR_Ptr holds.
- Wrap rule: for w=NUM_WARPS-1, the pointer becomes 0. This must be correct for non-power-of-2 NUM_WARPS; the pointer never takes a value >= NUM_WARPS.
- Exit arbitration:
  - Same round-robin scheme, using Exit_Ptr over Exit_Req_IB_IU & ~Req_IB_IU. A warp raising both requests is considered for issue only.
  - Not gated by Full_OC_IU.
  - Exit_Ptr <= (w+1) mod NUM_WARPS after an exit grant to w.
- Simultaneous events: one issue grant and one exit grant may be given in the same cycle, to different warps only. Both pointers update independently on that edge.
- Requests are level signals:
  - A warp still requesting after its grant loses priority to every other requester until the pointer rotates back to it.
  - Fairness guarantee: a continuously requesting warp is granted within NUM_WARPS grant cycles (excluding OC-full cycles).
- Issue_Count_IU: +1 on each edge with |Grt_IU_IB; wraps modulo 2^CNT_WIDTH.
- Stall_Count_IU:
  - +1 on each edge where Full_OC_IU=1 and |Req_IB_IU=1.
  - Saturates at all-ones; no wrap.
- Grant validity: grants depend only on current-cycle inputs and registered pointers. No combinational path from a grant back to the requests inside this block.
- Assertions for verification:
  - $onehot0(Grt_IU_IB) and $onehot0(Exit_Grt_IU_IB).
  - (Grt_IU_IB & Exit_Grt_IU_IB) == 0.
  - A grant is never given to a non-requesting warp.

Test Plan:
- Reset, then Req_IB_IU=8'hFF held for 9 cycles with Full_OC_IU=0 -> grants 0,1,...,7,0 one-hot in order; Issue_Count_IU=9.
- Req_IB_IU=8'b1000_0001 held, RR_Ptr=0 -> grants warp0, warp7, warp0, warp7; RR_Ptr sequence 1,0,1,0 (wrap from 7 to 0).
- Req_IB_IU=8'h0F with Full_OC_IU=1 for 5 cycles, then released -> Grt_IU_IB=0 during the stall; Stall_Count_IU=5; RR_Ptr unchanged; first grant afterwards goes to warp RR_Ptr.
- Req_IB_IU=8'h04 and Exit_Req_IB_IU=8'h24 in the same cycle -> Grt_IU_IB=8'h04, Exit_Grt_IU_IB=8'h20; both pointers update (RR_Ptr=3, Exit_Ptr=6).
- NUM_WARPS=6, requests on all warps -> grants cycle 0..5 then 0; the pointer never reaches 6 or 7.
- rst asserted asynchronously mid-cycle while grants are active -> both grant vectors drop to 0 before the next edge; pointers and counters read 0.
